vend_coin_collector: RTL and testbench

- Payment front-end that sits ahead of the vending machine datapath.
- Accepts coin pulses and accumulates credit.
- On a buy request, presents a 4-bit money value and a 2-bit product select over a valid/ack handshake.
- On cancel or inactivity, returns the accumulated credit as a one-cycle refund.

---
 rtl/vend_coin_collector.sv | 202 ++++++++++++++++++++
 tb/tb_vend_coin_collector.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_collector.sv
// ============================================================================
// Module   : vend_coin_collector
// Purpose  : Payment front-end for the vending machine. It accumulates coin
//            credit, presents money and the product select over a valid/ack
//            handshake on buy, and refunds credit on cancel or inactivity.
// Options  : VEND_COIN_COUNT_EN - adds the 16-bit o_total_collected counter
//            of money handed over in completed handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_coin_collector #(
  parameter int MAX_CREDIT     = 15,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_coin_valid,
  input  logic [1:0] i_coin_type,
  output logic       o_coin_reject,
  input  logic [1:0] i_select_in,
  input  logic       i_buy,
  input  logic       i_cancel,
  output logic [3:0] o_money_out,
  output logic [1:0] o_ps_out,
  output logic       o_money_valid,
  input  logic       i_money_ack,
  output logic [3:0] o_refund_out,
  output logic       o_refund_valid,
  output logic [3:0] o_credit,
  output logic       o_busy
`ifdef VEND_COIN_COUNT_EN
  ,
  output logic [15:0] o_total_collected
`endif
);

  // Counter only has to reach TIMEOUT_CYCLES-1 before the refund fires.
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [4:0]         c_max      = 5'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_credit,       w_credit_nxt;
  logic [c_cnt_w-1:0] r_cnt,          w_cnt_nxt;
  logic [3:0]         r_money_out,    w_money_out_nxt;
  logic [1:0]         r_ps_out,       w_ps_out_nxt;
  logic               r_money_valid,  w_money_valid_nxt;
  logic [3:0]         r_refund_out,   w_refund_out_nxt;
  logic               r_refund_valid, w_refund_valid_nxt;
  logic               r_coin_reject,  w_coin_reject_nxt;
  logic               r_busy;
  logic [4:0]         w_coin_val;
  logic [4:0]         w_sum;
  logic               w_fits;
  logic               w_sel_ok;

  // Decode the coin denomination and check whether it fits in the credit.
  always_comb begin
    w_coin_val = 5'd1;
    case (i_coin_type)
      2'b00:   w_coin_val = 5'd1;
      2'b01:   w_coin_val = 5'd2;
      2'b10:   w_coin_val = 5'd5;
      default: w_coin_val = 5'd10;
    endcase
    w_sum    = {1'b0, r_credit} + w_coin_val;
    w_fits   = (w_sum <= c_max);
    w_sel_ok = (i_select_in == 2'b01) || (i_select_in == 2'b10);
  end

  // Next state and next register values; any offered coin is rejected
  // unless a branch below explicitly accepts it.
  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_cnt_nxt          = r_cnt;
    w_money_out_nxt    = r_money_out;
    w_ps_out_nxt       = r_ps_out;
    w_money_valid_nxt  = r_money_valid;
    w_refund_out_nxt   = 4'd0;
    w_refund_valid_nxt = 1'b0;
    w_coin_reject_nxt  = i_coin_valid;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_coin_valid && w_fits) begin
          w_credit_nxt      = w_sum[3:0];
          w_coin_reject_nxt = 1'b0;
          w_state_nxt       = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_cancel) begin
          w_cnt_nxt = '0;
          if (r_credit != 4'd0) begin
            w_state_nxt        = S_REFUND;
            w_refund_valid_nxt = 1'b1;
            w_refund_out_nxt   = r_credit;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (i_buy && w_sel_ok) begin
          w_cnt_nxt         = '0;
          w_state_nxt       = S_PRESENT;
          w_money_valid_nxt = 1'b1;
          w_money_out_nxt   = r_credit;
          w_ps_out_nxt      = i_select_in;
        end else if (i_coin_valid && w_fits) begin
          // Any accepted coin counts as activity and restarts the timeout.
          w_credit_nxt      = w_sum[3:0];
          w_coin_reject_nxt = 1'b0;
          w_cnt_nxt         = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_cnt_nxt          = '0;
          w_state_nxt        = S_REFUND;
          w_refund_valid_nxt = 1'b1;
          w_refund_out_nxt   = r_credit;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      S_PRESENT: begin
        if (i_money_ack && r_money_valid) begin
          w_state_nxt       = S_IDLE;
          w_money_valid_nxt = 1'b0;
          w_credit_nxt      = 4'd0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_credit_nxt = 4'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Registered datapath and output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit       <= 4'd0;
      r_cnt          <= '0;
      r_money_out    <= 4'd0;
      r_ps_out       <= 2'd0;
      r_money_valid  <= 1'b0;
      r_refund_out   <= 4'd0;
      r_refund_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_credit       <= w_credit_nxt;
      r_cnt          <= w_cnt_nxt;
      r_money_out    <= w_money_out_nxt;
      r_ps_out       <= w_ps_out_nxt;
      r_money_valid  <= w_money_valid_nxt;
      r_refund_out   <= w_refund_out_nxt;
      r_refund_valid <= w_refund_valid_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_busy         <= (w_state_nxt == S_PRESENT) || (w_state_nxt == S_REFUND);
    end
  end

`ifdef VEND_COIN_COUNT_EN
  logic [15:0] r_total;

  // Running total of money handed over; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)
      r_total <= 16'd0;
    else if (r_state == S_PRESENT && r_money_valid && i_money_ack)
      r_total <= r_total + {12'd0, r_money_out};
  end

  assign o_total_collected = r_total;
`endif

  assign o_coin_reject  = r_coin_reject;
  assign o_money_out    = r_money_out;
  assign o_ps_out       = r_ps_out;
  assign o_money_valid  = r_money_valid;
  assign o_refund_out   = r_refund_out;
  assign o_refund_valid = r_refund_valid;
  assign o_credit       = r_credit;
  assign o_busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vend_coin_collector.sv
// ============================================================================
// Module   : tb_vend_coin_collector
// Purpose  : Directed self-checking bench for vend_coin_collector with a
//            behavioural payment model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_coin_collector;

  localparam int MAXC = 15;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic [1:0] select_in = 2'b00;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       money_ack = 1'b0;
  logic       coin_reject, money_valid, refund_valid, busy;
  logic [3:0] money_out, refund_out, credit;
  logic [1:0] ps_out;
`ifdef VEND_COIN_COUNT_EN
  logic [15:0] total;
`endif

  vend_coin_collector #(.MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_coin_valid   (coin_valid),
    .i_coin_type    (coin_type),
    .o_coin_reject  (coin_reject),
    .i_select_in    (select_in),
    .i_buy          (buy),
    .i_cancel       (cancel),
    .o_money_out    (money_out),
    .o_ps_out       (ps_out),
    .o_money_valid  (money_valid),
    .i_money_ack    (money_ack),
    .o_refund_out   (refund_out),
    .o_refund_valid (refund_valid),
    .o_credit       (credit),
    .o_busy         (busy)
`ifdef VEND_COIN_COUNT_EN
    ,
    .o_total_collected (total)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: "idle" is simply zero credit with nothing pending.
  typedef struct packed {
    int credit;
    int idle;
    int mout;
    int ps;
    int rout;
    int total;
    bit present;
    bit refund;
    bit mv;
    bit rv;
    bit rej;
  } m_t;

  m_t m;
  bit m_init = 1'b0;

  function automatic int coin_val(input logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 10;
    endcase
  endfunction

  function automatic m_t model_step(input m_t s, input bit rst, input bit cv,
                                    input logic [1:0] ct, input logic [1:0] sel,
                                    input bit b, input bit c, input bit ack);
    m_t  n;
    int  v;
    bit  honoured;
    bit  took;
    n = s;
    if (rst) begin
      n = '0;
      return n;
    end
    v        = coin_val(ct);
    n.rej    = 1'b0;
    n.rv     = 1'b0;
    n.rout   = 0;
    honoured = 1'b0;
    took     = 1'b0;
    if (s.refund) begin
      n.credit = 0;
      n.refund = 1'b0;
      n.rej    = cv;
    end else if (s.present) begin
      n.rej = cv;
      if (ack) begin
        n.total   = (s.total + s.mout) % 65536;
        n.credit  = 0;
        n.present = 1'b0;
        n.mv      = 1'b0;
      end
    end else if (s.credit == 0) begin
      if (cv) begin
        if (v <= MAXC) begin n.credit = v; n.idle = 0; end
        else n.rej = 1'b1;
      end
    end else begin
      if (c) begin
        honoured = 1'b1;
        n.refund = 1'b1; n.rv = 1'b1; n.rout = s.credit; n.idle = 0;
      end else if (b && (sel == 2'b01 || sel == 2'b10)) begin
        honoured  = 1'b1;
        n.present = 1'b1; n.mv = 1'b1; n.mout = s.credit; n.ps = int'(sel); n.idle = 0;
      end
      if (cv) begin
        if (honoured || s.credit + v > MAXC) n.rej = 1'b1;
        else begin n.credit = s.credit + v; n.idle = 0; took = 1'b1; end
      end
      if (!honoured && !took) begin
        if (s.idle == TO - 1) begin
          n.refund = 1'b1; n.rv = 1'b1; n.rout = s.credit; n.idle = 0;
        end else begin
          n.idle = s.idle + 1;
        end
      end
    end
    return n;
  endfunction

  // Advance the model on every active edge from the inputs the DUT sees.
  always @(posedge clk) begin
    m <= model_step(m, reset, coin_valid, coin_type, select_in, buy, cancel, money_ack);
    if (reset) m_init <= 1'b1;
  end

  // Compare DUT outputs against the model on the inactive edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("credit", int'(credit), m.credit);
      chk("coin_reject", int'(coin_reject), int'(m.rej));
      chk("money_valid", int'(money_valid), int'(m.mv));
      if (m.mv) begin
        chk("money_out", int'(money_out), m.mout);
        chk("ps_out", int'(ps_out), m.ps);
      end
      chk("refund_valid", int'(refund_valid), int'(m.rv));
      chk("refund_out", int'(refund_out), m.rout);
      chk("busy", int'(busy), int'(m.present || m.refund));
`ifdef VEND_COIN_COUNT_EN
      chk("total_collected", int'(total), m.total);
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  // Hand-computed expectation pinning both the DUT and the model.
  task automatic lit(input string nm, input int act, input int mdl, input int exp);
    chk({"lit_", nm}, act, exp);
    chk({"mdl_", nm}, mdl, exp);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    lit("reset_credit", int'(credit), m.credit, 0);
    lit("reset_mv", int'(money_valid), int'(m.mv), 0);
    chk("reset_busy", int'(busy), 0);

    // Ack and buy while idle are ignored.
    money_ack = 1'b1; buy = 1'b1; select_in = 2'b01;
    tick();
    money_ack = 1'b0; buy = 1'b0;
    lit("idle_ignore_mv", int'(money_valid), int'(m.mv), 0);

    // Purchase of 7 with a stalled ack.
    coin(2'b10);
    lit("t1_credit5", int'(credit), m.credit, 5);
    coin(2'b01);
    lit("t1_credit7", int'(credit), m.credit, 7);
    select_in = 2'b01; buy = 1'b1;
    tick();
    buy = 1'b0;
    lit("t1_mv", int'(money_valid), int'(m.mv), 1);
    lit("t1_mout", int'(money_out), m.mout, 7);
    lit("t1_ps", int'(ps_out), m.ps, 1);
    repeat (3) tick();
    lit("t1_hold_mout", int'(money_out), m.mout, 7);
    chk("t1_hold_busy", int'(busy), 1);
    money_ack = 1'b1;
    tick();
    money_ack = 1'b0;
    lit("t1_done_mv", int'(money_valid), int'(m.mv), 0);
    lit("t1_done_credit", int'(credit), m.credit, 0);

    // Overflowing coin is rejected, then 10+5 reaches the limit.
    coin(2'b11);
    coin(2'b11);
    lit("t2_reject", int'(coin_reject), int'(m.rej), 1);
    lit("t2_credit10", int'(credit), m.credit, 10);
    coin(2'b10);
    lit("t2_credit15", int'(credit), m.credit, 15);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    lit("t2_rout", int'(refund_out), m.rout, 15);
    tick();

    // Cancel wins over a simultaneous buy.
    coin(2'b10);
    coin(2'b00);
    lit("t3_credit6", int'(credit), m.credit, 6);
    cancel = 1'b1; buy = 1'b1; select_in = 2'b01;
    tick();
    cancel = 1'b0; buy = 1'b0;
    lit("t3_rv", int'(refund_valid), int'(m.rv), 1);
    lit("t3_rout", int'(refund_out), m.rout, 6);
    lit("t3_mv", int'(money_valid), int'(m.mv), 0);
    tick();
    lit("t3_credit0", int'(credit), m.credit, 0);
    lit("t3_rv_off", int'(refund_valid), int'(m.rv), 0);

    // Inactivity refund 8 edges after the coin is accepted.
    coin(2'b01);
    repeat (7) tick();
    lit("t4_no_rv_yet", int'(refund_valid), int'(m.rv), 0);
    tick();
    lit("t4_rv", int'(refund_valid), int'(m.rv), 1);
    lit("t4_rout", int'(refund_out), m.rout, 2);
    tick();
    lit("t4_credit0", int'(credit), m.credit, 0);

    // A second coin restarts the inactivity count.
    coin(2'b01);
    repeat (4) tick();
    coin(2'b00);
    lit("t4b_credit3", int'(credit), m.credit, 3);
    repeat (7) tick();
    lit("t4b_no_rv_yet", int'(refund_valid), int'(m.rv), 0);
    tick();
    lit("t4b_rv", int'(refund_valid), int'(m.rv), 1);
    lit("t4b_rout", int'(refund_out), m.rout, 3);
    tick();

    // Invalid select ignored; coin in PRESENT rejected; reset drops it.
    coin(2'b11);
    select_in = 2'b00; buy = 1'b1;
    tick();
    lit("t5_badsel_mv", int'(money_valid), int'(m.mv), 0);
    select_in = 2'b10;
    tick();
    buy = 1'b0;
    lit("t5_ps", int'(ps_out), m.ps, 2);
    coin(2'b00);
    lit("t5_reject", int'(coin_reject), int'(m.rej), 1);
    lit("t5_credit10", int'(credit), m.credit, 10);
    reset = 1'b1; money_ack = 1'b1;
    tick();
    reset = 1'b0; money_ack = 1'b0;
    lit("t5_rst_mv", int'(money_valid), int'(m.mv), 0);
    lit("t5_rst_credit", int'(credit), m.credit, 0);
    tick();
    lit("t5_rst_rv", int'(refund_valid), int'(m.rv), 0);

`ifdef VEND_COIN_COUNT_EN
    // Totals count completed purchases only.
    coin(2'b11); coin(2'b01);
    select_in = 2'b01; buy = 1'b1; tick(); buy = 1'b0;
    money_ack = 1'b1; tick(); money_ack = 1'b0;
    lit("t6_total12", int'(total), m.total, 12);
    coin(2'b01); coin(2'b01);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    lit("t6_after_refund", int'(total), m.total, 12);
    coin(2'b11); coin(2'b10);
    select_in = 2'b10; buy = 1'b1; tick(); buy = 1'b0;
    money_ack = 1'b1; tick(); money_ack = 1'b0;
    lit("t6_total27", int'(total), m.total, 27);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
